// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: arbitrates exception/resolve/replay/presolve sources into one fetch redirect
module fetch_redirect_ctrl #(
  parameter int SQUASH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        except_valid,
  input  logic [31:0] except_vec,
  input  logic        resolved_valid,
  input  logic        resolved_mispredict,
  input  logic        resolved_taken,
  input  logic [31:0] resolved_target,
  input  logic [31:0] resolved_pc,
  input  logic        replay_valid,
  input  logic [31:0] replay_vaddr,
  input  logic        presolved_mispredict,
  input  logic [31:0] presolved_target,
  input  logic        fetch_ready,
  output logic        redir_valid,
  output logic [31:0] redir_vaddr,
  output logic        flush_fetch,
  output logic        flush_decode,
  output logic        busy
);
  localparam logic [1:0] IDLE = 2'd0, PEND = 2'd1, SQUASH = 2'd2;
  localparam logic [2:0] SQ = 3'(SQUASH_CYCLES);
  logic [1:0] state, state_next;
  logic pend_valid;
  logic [1:0] pend_prio;
  logic [31:0] pend_target;
  logic [2:0] cnt, cnt_dec;
  logic res_act, pre_act, in_valid, use_pend, cand_valid, issue;
  logic [1:0] in_prio, cand_prio;
  logic [31:0] res_vaddr, in_target, cand_target;
  // Arbitrate incoming requests against the pending entry; incoming wins ties, presolve is muted while squashing
  always_comb begin
    res_act = resolved_valid & resolved_mispredict;
    pre_act = presolved_mispredict & (cnt == 3'd0);
    res_vaddr = resolved_taken ? resolved_target : resolved_pc + 32'd8;
    in_valid = except_valid | res_act | replay_valid | pre_act;
    in_prio = except_valid ? 2'd3 : res_act ? 2'd2 : replay_valid ? 2'd1 : 2'd0;
    in_target = except_valid ? except_vec : res_act ? res_vaddr : replay_valid ? replay_vaddr : presolved_target;
    use_pend = pend_valid & (!in_valid | (pend_prio > in_prio));
    cand_valid = in_valid | pend_valid;
    cand_prio = use_pend ? pend_prio : in_prio;
    cand_target = use_pend ? pend_target : in_target;
    issue = cand_valid & fetch_ready;
    cnt_dec = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
    state_next = issue ? ((SQ == 3'd0) ? IDLE : SQUASH) : cand_valid ? PEND : (cnt_dec != 3'd0) ? SQUASH : IDLE;
  end
  assign redir_valid = !rst & issue;
  assign redir_vaddr = redir_valid ? cand_target : 32'd0;
  assign flush_fetch = redir_valid;
  assign flush_decode = redir_valid & (cand_prio != 2'd0);
  assign busy = !rst & (state == PEND);
  // Hold the unissued winner, restart the squash window on every issue, otherwise count it down
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_valid <= 1'b0;
      pend_prio <= 2'd0;
      pend_target <= 32'd0;
      cnt <= 3'd0;
    end else begin
      state <= state_next;
      pend_valid <= cand_valid & !issue;
      pend_prio <= (cand_valid & !issue) ? cand_prio : 2'd0;
      pend_target <= (cand_valid & !issue) ? cand_target : 32'd0;
      cnt <= issue ? SQ : cnt_dec;
    end
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed and random checks against a priority-list reference model
module tb_fetch_redirect_ctrl;
  localparam int SQ = 2;
  logic clk = 1'b0, rst;
  logic except_valid, resolved_valid, resolved_mispredict, resolved_taken, replay_valid;
  logic presolved_mispredict, fetch_ready;
  logic [31:0] except_vec, resolved_target, resolved_pc, replay_vaddr, presolved_target;
  logic redir_valid, flush_fetch, flush_decode, busy;
  logic [31:0] redir_vaddr;
  int n_checks = 0, n_fail = 0;
  bit m_pv;
  int m_pp, m_cnt;
  logic [31:0] m_pt;
  bit e_rv, e_cv, e_rst;
  int e_cp;
  logic [31:0] e_ct;

  fetch_redirect_ctrl #(.SQUASH_CYCLES(SQ)) dut (
    .clk(clk), .rst(rst),
    .except_valid(except_valid), .except_vec(except_vec),
    .resolved_valid(resolved_valid), .resolved_mispredict(resolved_mispredict),
    .resolved_taken(resolved_taken), .resolved_target(resolved_target), .resolved_pc(resolved_pc),
    .replay_valid(replay_valid), .replay_vaddr(replay_vaddr),
    .presolved_mispredict(presolved_mispredict), .presolved_target(presolved_target),
    .fetch_ready(fetch_ready),
    .redir_valid(redir_valid), .redir_vaddr(redir_vaddr),
    .flush_fetch(flush_fetch), .flush_decode(flush_decode), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_in();
    except_valid = 0; resolved_valid = 0; resolved_mispredict = 0; resolved_taken = 0;
    replay_valid = 0; presolved_mispredict = 0; fetch_ready = 1;
    except_vec = 0; resolved_target = 0; resolved_pc = 0; replay_vaddr = 0; presolved_target = 0;
  endtask

  task automatic cmp();
    bit act[4];
    logic [31:0] tgt[4];
    int in_p;
    #4;
    act[3] = except_valid; tgt[3] = except_vec;
    act[2] = resolved_valid && resolved_mispredict;
    tgt[2] = resolved_taken ? resolved_target : resolved_pc + 32'd8;
    act[1] = replay_valid; tgt[1] = replay_vaddr;
    act[0] = presolved_mispredict && (m_cnt == 0); tgt[0] = presolved_target;
    in_p = -1;
    for (int p = 3; p >= 0; p--) if (act[p] && in_p < 0) in_p = p;
    e_cv = m_pv || (in_p >= 0);
    if (m_pv && m_pp > in_p) begin e_cp = m_pp; e_ct = m_pt; end
    else begin e_cp = in_p; e_ct = (in_p >= 0) ? tgt[in_p] : 32'd0; end
    e_rst = rst;
    e_rv = !rst && e_cv && fetch_ready;
    check("redir_valid", {31'd0, redir_valid}, {31'd0, e_rv});
    check("flush_fetch", {31'd0, flush_fetch}, {31'd0, e_rv});
    check("flush_decode", {31'd0, flush_decode}, {31'd0, e_rv && e_cp >= 1});
    check("busy", {31'd0, busy}, {31'd0, !rst && m_pv});
    if (e_rv) check("redir_vaddr", redir_vaddr, e_ct);
    if (rst) check("rst_vaddr", redir_vaddr, 32'd0);
  endtask

  task automatic adv();
    @(posedge clk);
    if (e_rst) begin m_pv = 0; m_pp = 0; m_pt = 0; m_cnt = 0; end
    else if (e_rv) begin m_pv = 0; m_cnt = SQ; end
    else begin
      if (e_cv) begin m_pv = 1; m_pp = e_cp; m_pt = e_ct; end
      m_cnt = (m_cnt > 0) ? m_cnt - 1 : 0;
    end
    #1;
  endtask

  task automatic cyc();
    cmp();
    adv();
  endtask

  initial begin
    m_pv = 0; m_pp = 0; m_pt = 0; m_cnt = 0;
    idle_in();
    rst = 1;
    except_valid = 1; except_vec = 32'hDEAD_BEEF;
    cmp();
    check("reset_valid", {31'd0, redir_valid}, 32'd0);
    adv();
    idle_in();
    cyc();
    rst = 0;
    repeat (4) cyc();

    resolved_valid = 1; resolved_mispredict = 1; resolved_pc = 32'h8000_0FFC;
    cmp();
    check("r33_valid", {31'd0, redir_valid}, 32'd1);
    check("r33_vaddr", redir_vaddr, 32'h8000_1004);
    check("r33_fdec", {31'd0, flush_decode}, 32'd1);
    adv();
    idle_in();
    repeat (3) cyc();

    except_valid = 1; except_vec = 32'hBFC0_0380; replay_valid = 1; replay_vaddr = 32'h8000_0100;
    cmp();
    check("r34_vaddr", redir_vaddr, 32'hBFC0_0380);
    adv();
    idle_in();
    cmp();
    check("r34_dropped", {31'd0, redir_valid}, 32'd0);
    adv();
    repeat (3) cyc();

    fetch_ready = 0; replay_valid = 1; replay_vaddr = 32'h100;
    cmp();
    check("r35_hold", {31'd0, redir_valid}, 32'd0);
    adv();
    idle_in(); fetch_ready = 0;
    resolved_valid = 1; resolved_mispredict = 1; resolved_taken = 1; resolved_target = 32'h200;
    cmp();
    check("r35_busy1", {31'd0, busy}, 32'd1);
    adv();
    idle_in();
    cmp();
    check("r35_busy2", {31'd0, busy}, 32'd1);
    check("r35_vaddr", redir_vaddr, 32'h200);
    adv();
    cmp();
    check("r35_single", {31'd0, redir_valid}, 32'd0);
    adv();
    repeat (3) cyc();

    replay_valid = 1; replay_vaddr = 32'h50;
    cyc();
    idle_in(); presolved_mispredict = 1; presolved_target = 32'h300;
    cmp();
    check("r36_squashed", {31'd0, redir_valid}, 32'd0);
    adv();
    idle_in();
    cyc();
    presolved_mispredict = 1; presolved_target = 32'h300;
    cmp();
    check("r36_valid", {31'd0, redir_valid}, 32'd1);
    check("r36_vaddr", redir_vaddr, 32'h300);
    check("r36_fdec", {31'd0, flush_decode}, 32'd0);
    adv();
    idle_in();
    repeat (3) cyc();

    resolved_valid = 1; resolved_mispredict = 1; resolved_pc = 32'hFFFF_FFFC;
    cmp();
    check("r37_wrap", redir_vaddr, 32'h0000_0004);
    adv();
    idle_in();
    repeat (3) cyc();

    fetch_ready = 0; replay_valid = 1; replay_vaddr = 32'h77;
    cyc();
    idle_in(); fetch_ready = 0; rst = 1;
    cyc();
    rst = 0;
    cmp();
    check("r38_busy", {31'd0, busy}, 32'd0);
    check("r38_valid", {31'd0, redir_valid}, 32'd0);
    adv();

    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      except_valid = ($urandom_range(0, 9) == 0);
      resolved_valid = ($urandom_range(0, 3) == 0);
      resolved_mispredict = $urandom_range(0, 1);
      resolved_taken = $urandom_range(0, 1);
      replay_valid = ($urandom_range(0, 5) == 0);
      presolved_mispredict = ($urandom_range(0, 2) == 0);
      fetch_ready = ($urandom_range(0, 2) != 0);
      except_vec = $urandom; resolved_target = $urandom;
      resolved_pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      replay_vaddr = $urandom; presolved_target = $urandom;
      cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
